// File: rtl/add_pipe.sv
// -----------------------------------------------------------------------------
// add_pipe -- pipelined add/subtract unit with valid/ready handshakes.
//
// Stage 1 computes a + b or a - b and registers the result, carry-out and
// signed overflow. Stages 2..STAGES delay that result unchanged. The whole pipe
// advances together whenever the output slot is empty or being consumed.
//
// Parameters
//   DATAWIDTH  operand/result width in bits (>= 2)
//   STAGES     pipeline depth = acceptance-to-out_valid latency (1..4)
//
// Optional feature macro
//   ADD_PIPE_SAT_EN  when defined, stage 1 clamps sum to the most positive or
//                    most negative value on signed overflow. cout and ovf still
//                    describe the unclamped result. When undefined, sum wraps
//                    modulo 2^DATAWIDTH.
//
// Ports
//   Clk        in   clock, all state changes on the rising edge
//   Rst        in   synchronous active-high reset, highest priority
//   in_valid   in   upstream beat valid
//   in_ready   out  pipe can accept a beat this cycle (combinational)
//   a, b       in   operands
//   sub        in   0: a+b, 1: a-b
//   out_valid  out  result beat valid
//   out_ready  in   downstream accepts the result this cycle
//   sum        out  result
//   cout       out  carry out (for subtraction, 1 = no borrow)
//   ovf        out  two's-complement signed overflow
// -----------------------------------------------------------------------------
module add_pipe #(
  parameter int DATAWIDTH = 8,
  parameter int STAGES    = 2
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  input  logic                 sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] sum,
  output logic                 cout,
  output logic                 ovf
);

  localparam int MSB = DATAWIDTH - 1;

  // Stage-1 next-state values.
  logic [DATAWIDTH-1:0] b_eff;
  logic [DATAWIDTH:0]   raw;
  logic [DATAWIDTH-1:0] sum_d;
  logic                 cout_d;
  logic                 ovf_d;

  // Pipeline registers; index 0 is stage 1, index STAGES-1 drives the outputs.
  logic                 valid_q [STAGES];
  logic [DATAWIDTH-1:0] sum_q   [STAGES];
  logic                 cout_q  [STAGES];
  logic                 ovf_q   [STAGES];

  logic adv;

  always_comb begin
    // Subtraction is a + ~b + 1, so the carry-in is simply sub.
    b_eff  = sub ? ~b : b;
    raw    = {1'b0, a} + {1'b0, b_eff} + {{DATAWIDTH{1'b0}}, sub};
    cout_d = raw[DATAWIDTH];
    ovf_d  = (a[MSB] == b_eff[MSB]) && (raw[MSB] != a[MSB]);
    // NOTE: sum_d gets its unconditional value first so the optional clamp
    // below is an override, never a path that leaves sum_d unassigned (latch).
    sum_d  = raw[MSB:0];
`ifdef ADD_PIPE_SAT_EN
    // Overflow can only happen when both operands share a sign; the sign of a
    // therefore tells which rail the true result ran past.
    if (ovf_d) begin
      sum_d = a[MSB] ? {1'b1, {(DATAWIDTH-1){1'b0}}}
                     : {1'b0, {(DATAWIDTH-1){1'b1}}};
    end
`endif
  end

  // The pipe moves only as a whole: an empty output slot or a consuming
  // downstream lets every stage shift. Bubbles travel along as invalid slots.
  assign adv      = ~valid_q[STAGES-1] | out_ready;
  assign in_ready = adv;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      // NOTE: the data registers are cleared too, not just the valid bits,
      // because the outputs must read zero straight out of reset.
      for (int i = 0; i < STAGES; i++) begin
        valid_q[i] <= 1'b0;
        sum_q[i]   <= '0;
        cout_q[i]  <= 1'b0;
        ovf_q[i]   <= 1'b0;
      end
    end else if (adv) begin
      // NOTE: non-blocking assignments make every stage read its neighbour's
      // old value, which is what turns this loop into a shift register.
      valid_q[0] <= in_valid;
      sum_q[0]   <= sum_d;
      cout_q[0]  <= cout_d;
      ovf_q[0]   <= ovf_d;
      for (int i = 1; i < STAGES; i++) begin
        valid_q[i] <= valid_q[i-1];
        sum_q[i]   <= sum_q[i-1];
        cout_q[i]  <= cout_q[i-1];
        ovf_q[i]   <= ovf_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign sum       = sum_q[STAGES-1];
  assign cout      = cout_q[STAGES-1];
  assign ovf       = ovf_q[STAGES-1];

endmodule

// File: tb/tb_add_pipe.sv
// -----------------------------------------------------------------------------
// tb_add_pipe -- directed self-checking bench for add_pipe (DATAWIDTH=8,
// STAGES=2). Inputs change and outputs are sampled 1-2 time units after the
// rising edge. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_add_pipe;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       sub;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       cout;
  logic       ovf;

  int checks = 0;
  int errors = 0;

  add_pipe #(.DATAWIDTH(8), .STAGES(2)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // One isolated beat with out_ready=1: not valid after one edge, valid with
  // the expected result after exactly two edges.
  task automatic beat_check(input string tag, input logic [7:0] av, input logic [7:0] bv,
                            input logic sv, input logic [7:0] es, input logic ec,
                            input logic eo);
    a = av; b = bv; sub = sv; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check({tag, ".in_ready"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    check({tag, ".lat1_valid"}, out_valid, 0);
    step();
    check({tag, ".out_valid"}, out_valid, 1);
    check({tag, ".sum"}, sum, es);
    check({tag, ".cout"}, cout, ec);
    check({tag, ".ovf"}, ovf, eo);
  endtask

  logic [7:0] exp4 [4] = '{8'h11, 8'h12, 8'h13, 8'h14};

  initial begin
    Rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b0;

    // 1. reset held for two edges
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst.out_valid", out_valid, 0);
      check("rst.sum", sum, 8'h00);
      check("rst.cout", cout, 0);
      check("rst.ovf", ovf, 0);
      check("rst.in_ready", in_ready, 1);
    end
    Rst = 1'b0;

    // 2. positive overflow
`ifdef ADD_PIPE_SAT_EN
    beat_check("t2", 8'h7F, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
`else
    beat_check("t2", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
`endif
    // 3. carry without overflow, then subtraction with borrow
    beat_check("t3a", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    beat_check("t3b", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
    // 6. negative overflow on subtraction
`ifdef ADD_PIPE_SAT_EN
    beat_check("t6", 8'h80, 8'h01, 1'b1, 8'h80, 1'b1, 1'b1);
`else
    beat_check("t6", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
`endif
    step();  // drain the last result

    // 4. four back-to-back beats with a 2-cycle stall on the first result
    begin
      int in_idx = 0;
      int out_idx = 0;
      int stall_left = 0;
      bit stalled_once = 1'b0;
      for (int cyc = 0; cyc < 20; cyc++) begin
        in_valid = (in_idx < 4);
        a = 8'(in_idx + 1);
        b = 8'h10;
        sub = 1'b0;
        if (out_valid && !stalled_once) begin
          stall_left = 2;
          stalled_once = 1'b1;
        end
        out_ready = (stall_left == 0);
        #1;
        if (stall_left > 0) begin
          check("t4.stall_in_ready", in_ready, 0);
          check("t4.stall_valid", out_valid, 1);
          check("t4.stall_sum", sum, 8'h11);
          stall_left--;
        end
        if (out_valid && out_ready) begin
          if (out_idx < 4) check("t4.sum", sum, exp4[out_idx]);
          else check("t4.extra_beat", out_idx, 4);
          out_idx++;
        end
        if (in_valid && in_ready) in_idx++;
        @(posedge Clk);
        #1;
      end
      in_valid = 1'b0;
      check("t4.beats_out", out_idx, 4);
      check("t4.stalled", stalled_once, 1);
    end

    // 5. reset with beats in flight
    out_ready = 1'b1;
    a = 8'h01; b = 8'h01; sub = 1'b0; in_valid = 1'b1;
    step();
    a = 8'h02; b = 8'h02; Rst = 1'b1;
    step();
    Rst = 1'b0; in_valid = 1'b0;
    check("t5.rst_valid", out_valid, 0);
    check("t5.rst_sum", sum, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5.no_ghost", out_valid, 0);
    end
    beat_check("t5new", 8'h20, 8'h03, 1'b0, 8'h23, 1'b0, 1'b0);
    step();
    check("t5.drained", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
